// File: rtl/hbm_stream_reader_pkg.sv
// rtl/hbm_stream_reader_pkg.sv - hbm_rd_pkg: state enum, AR constants and ARSIZE helper for hbm_stream_reader
package hbm_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [2:0] ARPROT_DEF   = 3'b010;
  localparam logic [3:0] ARCACHE_DEF  = 4'b0000;

  // Bytes per beat as an AXI size code; only 256- and 512-bit buses are legal.
  function automatic logic [2:0] arsize_of(input int unsigned dw);
    return (dw == 512) ? 3'b110 : 3'b101;
  endfunction

endpackage

// File: rtl/hbm_stream_reader_if.sv
// rtl/hbm_stream_reader_if.sv - AXI4 read channels plus downstream beat bus for hbm_stream_reader
interface hbm_stream_reader_if #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 5
);
  logic                  m_axi_ARVALID;
  logic                  m_axi_ARREADY;
  logic [ADDR_WIDTH-1:0] m_axi_ARADDR;
  logic [ID_WIDTH-1:0]   m_axi_ARID;
  logic [7:0]            m_axi_ARLEN;
  logic [2:0]            m_axi_ARSIZE;
  logic [1:0]            m_axi_ARBURST;
  logic                  m_axi_ARLOCK;
  logic [3:0]            m_axi_ARCACHE;
  logic [2:0]            m_axi_ARPROT;
  logic [3:0]            m_axi_ARQOS;
  logic [3:0]            m_axi_ARREGION;

  logic                  m_axi_RVALID;
  logic                  m_axi_RREADY;
  logic [DATA_WIDTH-1:0] m_axi_RDATA;
  logic                  m_axi_RLAST;
  logic [ID_WIDTH-1:0]   m_axi_RID;
  logic [1:0]            m_axi_RRESP;

  logic                  dn_vld;
  logic [DATA_WIDTH-1:0] dn_dat;
  logic                  dn_last;
  logic                  dn_rdy;

  modport master (
    output m_axi_ARVALID, m_axi_ARADDR, m_axi_ARID, m_axi_ARLEN, m_axi_ARSIZE,
           m_axi_ARBURST, m_axi_ARLOCK, m_axi_ARCACHE, m_axi_ARPROT, m_axi_ARQOS,
           m_axi_ARREGION, m_axi_RREADY, dn_vld, dn_dat, dn_last,
    input  m_axi_ARREADY, m_axi_RVALID, m_axi_RDATA, m_axi_RLAST, m_axi_RID,
           m_axi_RRESP, dn_rdy
  );

  modport slave (
    input  m_axi_ARVALID, m_axi_ARADDR, m_axi_ARID, m_axi_ARLEN, m_axi_ARSIZE,
           m_axi_ARBURST, m_axi_ARLOCK, m_axi_ARCACHE, m_axi_ARPROT, m_axi_ARQOS,
           m_axi_ARREGION, m_axi_RREADY, dn_vld, dn_dat, dn_last,
    output m_axi_ARREADY, m_axi_RVALID, m_axi_RDATA, m_axi_RLAST, m_axi_RID,
           m_axi_RRESP, dn_rdy
  );

endinterface

// File: rtl/hbm_stream_reader_addr_gen.sv
// rtl/hbm_stream_reader_addr_gen.sv - hbm_rd_addr_gen: 2-D burst index counters and row/column address accumulators
module hbm_rd_addr_gen #(
  parameter int ADDR_WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [15:0]           i_inner_cnt,
  input  logic [15:0]           i_outer_cnt,
  input  logic [31:0]           i_inner_stride,
  input  logic [31:0]           i_outer_stride,
  input  logic                  i_step,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last
);

  logic [ADDR_WIDTH-1:0] r_row_acc;
  logic [ADDR_WIDTH-1:0] r_col_acc;
  logic [15:0]           r_inner_idx;
  logic [15:0]           r_outer_idx;
  logic [15:0]           r_inner_cnt;
  logic [15:0]           r_outer_cnt;
  logic [31:0]           r_inner_stride;
  logic [31:0]           r_outer_stride;
  logic                  w_inner_wrap;
  logic [ADDR_WIDTH-1:0] w_row_next;

  assign w_inner_wrap = (r_inner_idx == r_inner_cnt - 16'd1);
  assign w_row_next   = r_row_acc + ADDR_WIDTH'(r_outer_stride);
  assign o_addr       = r_col_acc;
  assign o_last       = w_inner_wrap && (r_outer_idx == r_outer_cnt - 16'd1);

  // Load the job geometry, then advance one burst per AR handshake (inner index first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_acc      <= '0;
      r_col_acc      <= '0;
      r_inner_idx    <= '0;
      r_outer_idx    <= '0;
      r_inner_cnt    <= '0;
      r_outer_cnt    <= '0;
      r_inner_stride <= '0;
      r_outer_stride <= '0;
    end else if (i_load) begin
      r_row_acc      <= i_base;
      r_col_acc      <= i_base;
      r_inner_idx    <= '0;
      r_outer_idx    <= '0;
      r_inner_cnt    <= i_inner_cnt;
      r_outer_cnt    <= i_outer_cnt;
      r_inner_stride <= i_inner_stride;
      r_outer_stride <= i_outer_stride;
    end else if (i_step) begin
      if (w_inner_wrap) begin
        r_inner_idx <= '0;
        r_outer_idx <= r_outer_idx + 16'd1;
        r_row_acc   <= w_row_next;
        r_col_acc   <= w_row_next;
      end else begin
        r_inner_idx <= r_inner_idx + 16'd1;
        r_col_acc   <= r_col_acc + ADDR_WIDTH'(r_inner_stride);
      end
    end
  end

endmodule

// File: rtl/hbm_stream_reader.sv
// rtl/hbm_stream_reader.sv - 2-D strided AXI4 read engine with credit-limited issue; HBM_RD_RESP_CHECK_EN adds rd_err
module hbm_stream_reader
  import hbm_rd_pkg::*;
#(
  parameter int ENGINE_ID       = 0,
  parameter int ADDR_WIDTH      = 33,
  parameter int DATA_WIDTH      = 256,
  parameter int ID_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [27:0] cfg_base,
  input  logic [7:0]  cfg_arlen,
  input  logic [15:0] cfg_inner_cnt,
  input  logic [15:0] cfg_outer_cnt,
  input  logic [31:0] cfg_inner_stride,
  input  logic [31:0] cfg_outer_stride,
  output logic        busy,
  output logic        done,
`ifdef HBM_RD_RESP_CHECK_EN
  output logic        rd_err,
`endif
  hbm_stream_reader_if.master bus
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

  rd_state_t             r_state;
  rd_state_t             w_state_next;
  logic                  r_arvalid;
  logic [7:0]            r_arlen;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_next;
  logic                  r_done;
  logic                  w_start_acc;
  logic                  w_zero_job;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_rlast_hs;
  logic                  w_credit;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_base;

  assign w_start_acc = start && (r_state == IDLE);
  assign w_zero_job  = (cfg_inner_cnt == 16'd0) || (cfg_outer_cnt == 16'd0);
  assign w_ar_hs     = r_arvalid && bus.m_axi_ARREADY;
  assign w_r_hs      = bus.m_axi_RVALID && bus.m_axi_RREADY;
  assign w_rlast_hs  = w_r_hs && bus.m_axi_RLAST;
  assign w_credit    = (w_cnt_next < MAX_CNT);
  assign w_base      = ADDR_WIDTH'({1'b0, 4'(ENGINE_ID), cfg_base});

  hbm_rd_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_load         (w_start_acc),
    .i_base         (w_base),
    .i_inner_cnt    (cfg_inner_cnt),
    .i_outer_cnt    (cfg_outer_cnt),
    .i_inner_stride (cfg_inner_stride),
    .i_outer_stride (cfg_outer_stride),
    .i_step         (w_ar_hs),
    .o_addr         (w_addr),
    .o_last         (w_last)
  );

  // Outstanding count after this cycle's AR and RLAST handshakes, floored at zero.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_ar_hs && !w_rlast_hs) begin
      w_cnt_next = r_cnt + 8'd1;
    end else if (!w_ar_hs && w_rlast_hs && (r_cnt != 8'd0)) begin
      w_cnt_next = r_cnt - 8'd1;
    end
  end

  // State, credit counter, latched burst length and registered AR/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_arlen   <= '0;
      r_arvalid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= (w_start_acc && w_zero_job) || ((r_state == DRAIN) && (w_cnt_next == 8'd0));
      if (w_start_acc) begin
        r_arlen <= cfg_arlen;
      end
      if (r_state == IDLE) begin
        r_arvalid <= w_start_acc && !w_zero_job && w_credit;
      end else if (r_state == ISSUE) begin
        // A pending request holds until accepted; otherwise raise only with credit left.
        r_arvalid <= (r_arvalid && !bus.m_axi_ARREADY) || (!(w_ar_hs && w_last) && w_credit);
      end else begin
        r_arvalid <= 1'b0;
      end
    end
  end

  // Next-state decode for the issue/drain sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_acc && !w_zero_job) w_state_next = ISSUE;
      ISSUE:   if (w_ar_hs && w_last) w_state_next = DRAIN;
      DRAIN:   if (w_cnt_next == 8'd0) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = (r_state != IDLE);
    done = r_done;
  end

`ifdef HBM_RD_RESP_CHECK_EN
  logic r_rd_err;

  // Sticky flag for any accepted beat with an error response or a foreign ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_err <= 1'b0;
    end else if (w_start_acc) begin
      r_rd_err <= 1'b0;
    end else if (w_r_hs && ((bus.m_axi_RRESP != 2'b00) || (bus.m_axi_RID != '0))) begin
      r_rd_err <= 1'b1;
    end
  end

  assign rd_err = r_rd_err;
`else
  logic w_unused_resp;
  assign w_unused_resp = ^{bus.m_axi_RRESP, bus.m_axi_RID};
`endif

  assign bus.m_axi_ARVALID  = r_arvalid;
  assign bus.m_axi_ARADDR   = w_addr;
  assign bus.m_axi_ARID     = {ID_WIDTH{1'b0}};
  assign bus.m_axi_ARLEN    = r_arlen;
  assign bus.m_axi_ARSIZE   = arsize_of(DATA_WIDTH);
  assign bus.m_axi_ARBURST  = ARBURST_INCR;
  assign bus.m_axi_ARLOCK   = 1'b0;
  assign bus.m_axi_ARCACHE  = ARCACHE_DEF;
  assign bus.m_axi_ARPROT   = ARPROT_DEF;
  assign bus.m_axi_ARQOS    = 4'd0;
  assign bus.m_axi_ARREGION = 4'd0;

  assign bus.dn_vld       = bus.m_axi_RVALID;
  assign bus.dn_dat       = bus.m_axi_RDATA;
  assign bus.dn_last      = bus.m_axi_RLAST;
  assign bus.m_axi_RREADY = bus.dn_rdy;

endmodule

// File: tb/tb_hbm_stream_reader.sv
// tb/tb_hbm_stream_reader.sv - directed self-checking bench for hbm_stream_reader
module tb_hbm_stream_reader;

  localparam int AW   = 33;
  localparam int DW   = 256;
  localparam int IW   = 5;
  localparam int EID  = 2;
  localparam int MAXO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [27:0] cfg_base = '0;
  logic [7:0]  cfg_arlen = '0;
  logic [15:0] cfg_inner_cnt = '0;
  logic [15:0] cfg_outer_cnt = '0;
  logic [31:0] cfg_inner_stride = '0;
  logic [31:0] cfg_outer_stride = '0;
  logic        busy;
  logic        done;
`ifdef HBM_RD_RESP_CHECK_EN
  logic        rd_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hbm_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  hbm_stream_reader #(
    .ENGINE_ID(EID), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .cfg_base         (cfg_base),
    .cfg_arlen        (cfg_arlen),
    .cfg_inner_cnt    (cfg_inner_cnt),
    .cfg_outer_cnt    (cfg_outer_cnt),
    .cfg_inner_stride (cfg_inner_stride),
    .cfg_outer_stride (cfg_outer_stride),
    .busy             (busy),
    .done             (done),
`ifdef HBM_RD_RESP_CHECK_EN
    .rd_err           (rd_err),
`endif
    .bus              (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_job(input logic [27:0] base, input logic [7:0] arlen,
                         input logic [15:0] ic, input logic [31:0] is,
                         input logic [15:0] oc, input logic [31:0] os);
    cfg_base = base; cfg_arlen = arlen;
    cfg_inner_cnt = ic; cfg_inner_stride = is;
    cfg_outer_cnt = oc; cfg_outer_stride = os;
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One R beat presented for a single cycle with dn_rdy high.
  task automatic beat(input logic [63:0] dat, input logic last, input logic [1:0] resp);
    bus.m_axi_RVALID = 1'b1;
    bus.m_axi_RDATA  = DW'(dat);
    bus.m_axi_RLAST  = last;
    bus.m_axi_RRESP  = resp;
    #1;
    check("dn_vld", bus.dn_vld, 1'b1);
    check("dn_dat", bus.dn_dat[63:0], dat);
    check("dn_last", bus.dn_last, last);
    check("rready", bus.m_axi_RREADY, 1'b1);
    check("no_early_done", done, 1'b0);
    @(negedge clk);
    bus.m_axi_RVALID = 1'b0;
    bus.m_axi_RLAST  = 1'b0;
    bus.m_axi_RRESP  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] offs2d [6];
    int n_ar;
    offs2d[0] = 64'h0;    offs2d[1] = 64'h40;   offs2d[2] = 64'h1000;
    offs2d[3] = 64'h1040; offs2d[4] = 64'h2000; offs2d[5] = 64'h2040;

    bus.m_axi_ARREADY = 1'b1;
    bus.m_axi_RVALID  = 1'b0;
    bus.m_axi_RDATA   = '0;
    bus.m_axi_RLAST   = 1'b0;
    bus.m_axi_RID     = '0;
    bus.m_axi_RRESP   = 2'b00;
    bus.dn_rdy        = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_arvalid", bus.m_axi_ARVALID, 1'b0);
    check("rst_araddr", bus.m_axi_ARADDR, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_arsize", bus.m_axi_ARSIZE, 3'b101);
    check("rst_arburst", bus.m_axi_ARBURST, 2'b01);
    check("rst_arprot", bus.m_axi_ARPROT, 3'b010);
    check("rst_arcache", bus.m_axi_ARCACHE, 4'h0);
    check("rst_arid", bus.m_axi_ARID, 5'h0);
`ifdef HBM_RD_RESP_CHECK_EN
    check("rst_rd_err", rd_err, 1'b0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Basic job: 4 bursts of 8 beats, 0x100 apart, port 2
    set_job(28'h100, 8'd7, 16'd4, 32'h100, 16'd1, 32'h0);
    pulse_start();
    check("basic_busy", busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("basic_arvalid", bus.m_axi_ARVALID, 1'b1);
      check("basic_araddr", bus.m_axi_ARADDR, 64'h2000_0100 + 64'(k) * 64'h100);
      check("basic_arlen", bus.m_axi_ARLEN, 8'd7);
      @(negedge clk);
    end
    check("basic_ar_idle", bus.m_axi_ARVALID, 1'b0);
    check("basic_busy_drain", busy, 1'b1);
    for (int b = 0; b < 32; b++) beat(64'h1000 + 64'(b), (b % 8) == 7, 2'b00);
    check("basic_done", done, 1'b1);
    check("basic_busy_end", busy, 1'b0);
    @(negedge clk);
    check("basic_done_pulse", done, 1'b0);

    // 2-D job: 2 bursts per row, 3 rows
    set_job(28'h0, 8'd0, 16'd2, 32'h40, 16'd3, 32'h1000);
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      check("twod_arvalid", bus.m_axi_ARVALID, 1'b1);
      check("twod_araddr", bus.m_axi_ARADDR, 64'h2000_0000 + offs2d[k]);
      @(negedge clk);
    end
    check("twod_ar_idle", bus.m_axi_ARVALID, 1'b0);
    for (int b = 0; b < 6; b++) beat(64'h2000 + 64'(b), 1'b1, 2'b00);
    check("twod_done", done, 1'b1);

    // Credit limit: 10 single-beat bursts, no responses at first
    set_job(28'h0, 8'd0, 16'd10, 32'h10, 16'd1, 32'h0);
    pulse_start();
    n_ar = 0;
    for (int c = 0; c < 14; c++) begin
      if (bus.m_axi_ARVALID) n_ar++;
      @(negedge clk);
    end
    check("credit_ar_count", 64'(n_ar), 64'd8);
    check("credit_ar_stalled", bus.m_axi_ARVALID, 1'b0);
    beat(64'h30, 1'b1, 2'b00);
    check("credit_reissue", bus.m_axi_ARVALID, 1'b1);
    check("credit_addr", bus.m_axi_ARADDR, 64'h2000_0080);
    for (int b = 0; b < 9; b++) beat(64'h31 + 64'(b), 1'b1, 2'b00);
    check("credit_done", done, 1'b1);

    // Backpressure on AR and on the downstream side
    set_job(28'h40, 8'd1, 16'd2, 32'h100, 16'd1, 32'h0);
    bus.m_axi_ARREADY = 1'b0;
    pulse_start();
    for (int c = 0; c < 5; c++) begin
      check("bp_arvalid_hold", bus.m_axi_ARVALID, 1'b1);
      check("bp_araddr_hold", bus.m_axi_ARADDR, 64'h2000_0040);
      @(negedge clk);
    end
    bus.m_axi_ARREADY = 1'b1;
    @(negedge clk);
    check("bp_araddr2", bus.m_axi_ARADDR, 64'h2000_0140);
    check("bp_arvalid2", bus.m_axi_ARVALID, 1'b1);
    @(negedge clk);
    check("bp_ar_idle", bus.m_axi_ARVALID, 1'b0);
    bus.dn_rdy = 1'b0;
    bus.m_axi_RVALID = 1'b1;
    bus.m_axi_RDATA = DW'(64'hAA);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_rready_low", bus.m_axi_RREADY, 1'b0);
      check("bp_dn_vld", bus.dn_vld, 1'b1);
      check("bp_dn_dat", bus.dn_dat[63:0], 64'hAA);
      @(negedge clk);
    end
    bus.m_axi_RVALID = 1'b0;
    bus.dn_rdy = 1'b1;
    beat(64'hAA, 1'b0, 2'b00);
    beat(64'hAB, 1'b1, 2'b00);
    check("bp_busy_mid", busy, 1'b1);
    beat(64'hAC, 1'b0, 2'b00);
    beat(64'hAD, 1'b1, 2'b00);
    check("bp_done", done, 1'b1);

    // Zero count: done on the next cycle, no AR
    set_job(28'h0, 8'd0, 16'd4, 32'h10, 16'd0, 32'h0);
    pulse_start();
    check("zero_done", done, 1'b1);
    check("zero_arvalid", bus.m_axi_ARVALID, 1'b0);
    check("zero_busy", busy, 1'b0);
    @(negedge clk);
    check("zero_done_pulse", done, 1'b0);
    check("zero_arvalid2", bus.m_axi_ARVALID, 1'b0);

    // Start while busy is ignored
    set_job(28'h500, 8'd0, 16'd1, 32'h0, 16'd1, 32'h0);
    bus.m_axi_ARREADY = 1'b0;
    pulse_start();
    check("ign_addr0", bus.m_axi_ARADDR, 64'h2000_0500);
    cfg_base = 28'h900;
    pulse_start();
    check("ign_addr1", bus.m_axi_ARADDR, 64'h2000_0500);
    check("ign_busy", busy, 1'b1);
    bus.m_axi_ARREADY = 1'b1;
    @(negedge clk);
    check("ign_ar_idle", bus.m_axi_ARVALID, 1'b0);
    beat(64'h55, 1'b1, 2'b00);
    check("ign_done", done, 1'b1);
    @(negedge clk);
    check("ign_no_second_job", busy, 1'b0);
    check("ign_no_second_ar", bus.m_axi_ARVALID, 1'b0);

`ifdef HBM_RD_RESP_CHECK_EN
    // Response check: SLVERR on one beat flags rd_err, job still completes
    set_job(28'h0, 8'd1, 16'd1, 32'h0, 16'd1, 32'h0);
    pulse_start();
    @(negedge clk);
    beat(64'h1, 1'b0, 2'b10);
    check("err_set", rd_err, 1'b1);
    beat(64'h2, 1'b1, 2'b00);
    check("err_done", done, 1'b1);
    check("err_sticky", rd_err, 1'b1);
    pulse_start();
    check("err_cleared", rd_err, 1'b0);
    @(negedge clk);
    beat(64'h3, 1'b0, 2'b00);
    beat(64'h4, 1'b1, 2'b00);
    check("err_done2", done, 1'b1);
    check("err_clean", rd_err, 1'b0);
`endif

    // Asynchronous reset mid-job, then a stray RLAST and a fresh job
    set_job(28'h0, 8'd0, 16'd4, 32'h10, 16'd1, 32'h0);
    bus.m_axi_ARREADY = 1'b0;
    pulse_start();
    check("mid_arvalid", bus.m_axi_ARVALID, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_arvalid", bus.m_axi_ARVALID, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_araddr", bus.m_axi_ARADDR, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_axi_ARREADY = 1'b1;
    beat(64'h77, 1'b1, 2'b00);
    check("stray_busy", busy, 1'b0);
    check("stray_done", done, 1'b0);
    set_job(28'h20, 8'd0, 16'd1, 32'h0, 16'd1, 32'h0);
    pulse_start();
    check("post_rst_addr", bus.m_axi_ARADDR, 64'h2000_0020);
    @(negedge clk);
    beat(64'h78, 1'b1, 2'b00);
    check("post_rst_done", done, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
